fmc151_init_seq: RTL and testbench

//  Top-level FMC151 bring-up sequencer. Drives the SPI init stages in order: clock chip, ADC test-pattern config, ADC data-eye training, ADC normal config, DAC.

---
 rtl/fmc151_init_seq_pkg.sv | 26 ++
 rtl/fmc151_init_seq_pattern_check.sv | 43 ++++
 rtl/fmc151_init_seq.sv | 196 +++++++++++++++++++
 tb/tb_fmc151_init_seq.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fmc151_init_seq_pkg.sv
// Shared types and defaults for the FMC151 bring-up sequencer.
// Optional DAC stage is built when FMC151_INIT_DAC_EN is defined.
package fmc151_init_seq_pkg;

   typedef enum logic [11:0] {
      S_IDLE      = 12'h001,
      S_CLK       = 12'h002,
      S_ADS_TEST  = 12'h004,
      S_TR_LOAD   = 12'h008,
      S_TR_SETTLE = 12'h010,
      S_TR_CHECK  = 12'h020,
      S_TR_NEXT   = 12'h040,
      S_TR_APPLY  = 12'h080,
      S_ADS_NORM  = 12'h100,
      S_DAC       = 12'h200,
      S_DONE      = 12'h400,
      S_FAIL      = 12'h800
   } state_t;

   localparam logic [13:0] PATTERN_DEF = 14'h2AAA;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/fmc151_init_seq_pattern_check.sv
// Counts consecutive samples where both ADC channels carry the test pattern.
// Sticky pass after MATCH_LEN matches, sticky fail on any mismatch.
module fmc151_init_seq_pattern_check
   import fmc151_init_seq_pkg::*;
#(
   parameter int            DW        = 14,
   parameter logic [DW-1:0] PATTERN   = DW'(PATTERN_DEF),
   parameter int            MATCH_LEN = 256
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          en,
   input  logic [DW-1:0] data_a,
   input  logic [DW-1:0] data_b,
   output logic          pass,
   output logic          fail
);

   localparam int MW = $clog2(MATCH_LEN + 1);

   logic [MW-1:0] cnt;
   logic          match;

   assign match = (data_a == PATTERN) && (data_b == PATTERN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         pass <= 1'b0;
         fail <= 1'b0;
      end else if (clr) begin
         cnt  <= '0;
         pass <= 1'b0;
         fail <= 1'b0;
      end else if (en && !pass && !fail) begin
         if (!match) fail <= 1'b1;
         else if (cnt == MW'(MATCH_LEN - 1)) pass <= 1'b1;
         else cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/fmc151_init_seq.sv
// FMC151 bring-up: clock chip, ADC test config, IDELAY eye training,
// ADC normal config, optional DAC stage (FMC151_INIT_DAC_EN).
module fmc151_init_seq
   import fmc151_init_seq_pkg::*;
#(
   parameter int            DW        = 14,
   parameter logic [DW-1:0] PATTERN   = DW'(PATTERN_DEF),
   parameter int            TAP_W     = 5,
   parameter int            SETTLE    = 32,
   parameter int            MATCH_LEN = 256,
   parameter int            TIMEOUT   = 2**20
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             init_cdce_ena,
   input  logic             init_cdce_done,
   output logic             init_ads_ena,
   input  logic             init_ads_done,
   output logic             adc_calibrated,
   output logic             init_dac_ena,
   input  logic             init_dac_done,
   input  logic [DW-1:0]    adc_data_a,
   input  logic [DW-1:0]    adc_data_b,
   output logic [TAP_W-1:0] idelay_tap,
   output logic             idelay_ld,
   output logic             seq_done,
   output logic             seq_fail
);

   localparam int CW = $clog2(max2(TIMEOUT, SETTLE) + 1);
   localparam logic [TAP_W-1:0] TAP_MAX = '1;

`ifdef FMC151_INIT_DAC_EN
   localparam state_t NORM_NEXT = S_DAC;
`else
   localparam state_t NORM_NEXT = S_DONE;
   logic unused_dac_done;
   assign unused_dac_done = init_dac_done;
`endif

   state_t           state, state_d, nxt;
   logic [CW-1:0]    cnt, cnt_d;
   logic             hs, hs_d, start_q;
   logic [TAP_W-1:0] tap, tap_d, first, first_d, last, last_d;
   logic             have, have_d, ld_d, cal_d;
   logic             in_stage, stage_done, dac_ena;
   logic             chk_pass, chk_fail;
   logic [TAP_W:0]   sum;

   assign sum = {1'b0, first} + {1'b0, last};

   always_comb begin
      state_d       = state;
      nxt           = S_IDLE;
      cnt_d         = cnt + 1'b1;
      hs_d          = hs;
      tap_d         = tap;
      first_d       = first;
      last_d        = last;
      have_d        = have;
      ld_d          = 1'b0;
      cal_d         = adc_calibrated;
      in_stage      = 1'b0;
      stage_done    = 1'b0;
      init_cdce_ena = 1'b0;
      init_ads_ena  = 1'b0;
      dac_ena       = 1'b0;
      unique case (state)
         S_IDLE: if (start && !start_q) begin
            state_d = S_CLK;
            tap_d   = '0;
            have_d  = 1'b0;
            cal_d   = 1'b0;
         end
         S_CLK: begin
            in_stage      = 1'b1;
            stage_done    = init_cdce_done;
            init_cdce_ena = !hs;
            nxt           = S_ADS_TEST;
         end
         S_ADS_TEST: begin
            in_stage     = 1'b1;
            stage_done   = init_ads_done;
            init_ads_ena = !hs;
            nxt          = S_TR_LOAD;
         end
         S_TR_LOAD: begin
            ld_d    = 1'b1;
            state_d = S_TR_SETTLE;
         end
         S_TR_SETTLE:
            if (cnt == CW'(SETTLE - 1)) state_d = S_TR_CHECK;
         S_TR_CHECK:
            if (chk_pass || chk_fail) state_d = S_TR_NEXT;
         S_TR_NEXT: begin
            state_d = S_TR_LOAD;
            tap_d   = tap + 1'b1;
            if (chk_pass) begin
               last_d = tap;
               have_d = 1'b1;
               if (!have) first_d = tap;
            end
            // first fail after a pass closes the window
            if ((chk_fail && have) || tap == TAP_MAX) begin
               state_d = S_TR_APPLY;
               tap_d   = tap;
            end
         end
         S_TR_APPLY:
            if (!have) state_d = S_FAIL;
            else begin
               tap_d   = sum[TAP_W:1];
               ld_d    = 1'b1;
               cal_d   = 1'b1;
               state_d = S_ADS_NORM;
            end
         S_ADS_NORM: begin
            in_stage     = 1'b1;
            stage_done   = init_ads_done;
            init_ads_ena = !hs;
            nxt          = NORM_NEXT;
         end
         S_DAC: begin
`ifdef FMC151_INIT_DAC_EN
            in_stage   = 1'b1;
            stage_done = init_dac_done;
            dac_ena    = !hs;
            nxt        = S_DONE;
`else
            state_d    = S_FAIL;
`endif
         end
         S_DONE: if (!start) state_d = S_IDLE;
         S_FAIL: if (!start && start_q) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // stage leaves only after done has been seen high and then low
      if (in_stage) begin
         if (!hs && stage_done) hs_d = 1'b1;
         if (hs && !stage_done) state_d = nxt;
         else if (cnt == CW'(TIMEOUT - 1)) state_d = S_FAIL;
      end
      if (state_d != state) begin
         cnt_d = '0;
         hs_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         cnt            <= '0;
         hs             <= 1'b0;
         start_q        <= 1'b0;
         tap            <= '0;
         first          <= '0;
         last           <= '0;
         have           <= 1'b0;
         idelay_ld      <= 1'b0;
         adc_calibrated <= 1'b0;
      end else begin
         state          <= state_d;
         cnt            <= cnt_d;
         hs             <= hs_d;
         start_q        <= start;
         tap            <= tap_d;
         first          <= first_d;
         last           <= last_d;
         have           <= have_d;
         idelay_ld      <= ld_d;
         adc_calibrated <= cal_d;
      end
   end

   assign idelay_tap   = tap;
   assign init_dac_ena = dac_ena;
   assign seq_done     = (state == S_DONE);
   assign seq_fail     = (state == S_FAIL);

   fmc151_init_seq_pattern_check #(
      .DW        (DW),
      .PATTERN   (PATTERN),
      .MATCH_LEN (MATCH_LEN)
   ) u_chk (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (state == S_TR_LOAD),
      .en     (state == S_TR_CHECK),
      .data_a (adc_data_a),
      .data_b (adc_data_b),
      .pass   (chk_pass),
      .fail   (chk_fail)
   );

endmodule

// File: tb/tb_fmc151_init_seq.sv
// Scoreboard bench for fmc151_init_seq with stage models and an eye model.
`timescale 1ns/1ps
module tb_fmc151_init_seq;

   localparam int DW = 14, TAP_W = 5, SETTLE = 4, MATCH_LEN = 8;
   localparam int TIMEOUT = 400;
   localparam logic [DW-1:0] PAT = 14'h2AAA;
`ifdef FMC151_INIT_DAC_EN
   localparam int EXP_DAC = 1;
`else
   localparam int EXP_DAC = 0;
`endif

   logic clk = 0, rst_n = 0, start = 0;
   logic init_cdce_ena, init_ads_ena, init_dac_ena, adc_calibrated;
   logic init_cdce_done = 0, init_ads_done = 0, init_dac_done = 0;
   logic [DW-1:0] adc_data_a = '0, adc_data_b = '0;
   logic [TAP_W-1:0] idelay_tap;
   logic idelay_ld, seq_done, seq_fail;

   typedef struct {
      logic [TAP_W-1:0] tap;
      logic done;
      logic fail;
      logic cal;
      int   lds;
      int   rises;
   } exp_t;

   exp_t sb[$];
   int errors = 0, checks = 0;
   int eye_lo = 1, eye_hi = 0;
   bit ads_hang = 0;
   int lds = 0, rises = 0, dac_rises = 0, cal_viol = 0;
   int cdce_cnt = 0, ads_cnt = 0, dac_cnt = 0;
   logic ads_q = 0, dac_q = 0, cal_q = 0;
   logic [TAP_W-1:0] cur_tap = '0;

   fmc151_init_seq #(
      .DW(DW), .PATTERN(PAT), .TAP_W(TAP_W), .SETTLE(SETTLE),
      .MATCH_LEN(MATCH_LEN), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .init_cdce_ena(init_cdce_ena), .init_cdce_done(init_cdce_done),
      .init_ads_ena(init_ads_ena), .init_ads_done(init_ads_done),
      .adc_calibrated(adc_calibrated),
      .init_dac_ena(init_dac_ena), .init_dac_done(init_dac_done),
      .adc_data_a(adc_data_a), .adc_data_b(adc_data_b),
      .idelay_tap(idelay_tap), .idelay_ld(idelay_ld),
      .seq_done(seq_done), .seq_fail(seq_fail)
   );

   always #5 clk = ~clk;

   // stage models, IDELAY/eye model and monitors, all on the falling edge
   always @(negedge clk) begin
      if (idelay_ld) begin
         cur_tap = idelay_tap;
         lds++;
      end
      if (int'(cur_tap) >= eye_lo && int'(cur_tap) <= eye_hi) begin
         adc_data_a = PAT;
         adc_data_b = PAT;
      end else if (cur_tap[0]) begin
         adc_data_a = PAT;
         adc_data_b = ~PAT;
      end else begin
         adc_data_a = ~PAT;
         adc_data_b = PAT;
      end
      cdce_cnt = init_cdce_ena ? cdce_cnt + 1 : 0;
      ads_cnt  = init_ads_ena ? ads_cnt + 1 : 0;
      dac_cnt  = init_dac_ena ? dac_cnt + 1 : 0;
      init_cdce_done = (cdce_cnt >= 10);
      init_ads_done  = (ads_cnt >= 10) && !ads_hang;
      init_dac_done  = (dac_cnt >= 10);
      if (init_ads_ena && !ads_q) rises++;
      if (init_dac_ena && !dac_q) dac_rises++;
      if (adc_calibrated !== cal_q && ads_q) cal_viol++;
      ads_q = init_ads_ena;
      dac_q = init_dac_ena;
      cal_q = adc_calibrated;
   end

   task automatic run_eye(input int lo, input int hi, input exp_t e);
      exp_t x;
      int l0, r0;
      bit ok;
      eye_lo = lo;
      eye_hi = hi;
      l0 = lds;
      r0 = rises;
      sb.push_back(e);
      start = 1;
      ok = 0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (seq_done || seq_fail) begin
            ok = 1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL end_wait eye=%0d..%0d: no done/fail in 4000 cycles", lo, hi);
      end
      x = sb.pop_front();
      checks += 6;
      if (idelay_tap !== x.tap) begin
         errors++;
         $display("FAIL tap eye=%0d..%0d: got %0d want %0d", lo, hi, idelay_tap, x.tap);
      end
      if (seq_done !== x.done) begin
         errors++;
         $display("FAIL seq_done eye=%0d..%0d: got %b want %b", lo, hi, seq_done, x.done);
      end
      if (seq_fail !== x.fail) begin
         errors++;
         $display("FAIL seq_fail eye=%0d..%0d: got %b want %b", lo, hi, seq_fail, x.fail);
      end
      if (adc_calibrated !== x.cal) begin
         errors++;
         $display("FAIL cal eye=%0d..%0d: got %b want %b", lo, hi, adc_calibrated, x.cal);
      end
      if (lds - l0 != x.lds) begin
         errors++;
         $display("FAIL ld_count eye=%0d..%0d: got %0d want %0d", lo, hi, lds - l0, x.lds);
      end
      if (rises - r0 != x.rises) begin
         errors++;
         $display("FAIL ads_ena_rises eye=%0d..%0d: got %0d want %0d", lo, hi, rises - r0, x.rises);
      end
      start = 0;
      repeat (3) @(negedge clk);
      checks += 2;
      if (seq_done !== 1'b0 || seq_fail !== 1'b0) begin
         errors++;
         $display("FAIL back_to_idle: got done=%b fail=%b want 0 0", seq_done, seq_fail);
      end
      if (adc_calibrated !== x.cal) begin
         errors++;
         $display("FAIL cal_held: got %b want %b", adc_calibrated, x.cal);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      logic [11:0] v;
      v = {init_cdce_ena, init_ads_ena, adc_calibrated, init_dac_ena,
           idelay_tap, idelay_ld, seq_done, seq_fail};
      checks++;
      if (v !== 12'h000) begin
         errors++;
         $display("FAIL %s: outputs got %h want 000", tag, v);
      end
   endtask

   task automatic test_reset();
      rst_n = 0;
      start = 0;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset_state");
      rst_n = 1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_nominal();
      run_eye(6, 12, '{tap: 9, done: 1, fail: 0, cal: 1, lds: 15, rises: 2});
   endtask

   task automatic test_no_eye();
      run_eye(1, 0, '{tap: 31, done: 0, fail: 1, cal: 0, lds: 32, rises: 1});
   endtask

   task automatic test_timeout();
      int n;
      bit seen;
      ads_hang = 1;
      start = 1;
      seen = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (init_ads_ena) begin
            seen = 1;
            break;
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL timeout_entry: init_ads_ena never rose");
      end
      n = 0;
      for (int i = 0; i < TIMEOUT + 100; i++) begin
         @(negedge clk);
         n++;
         if (seq_fail) break;
      end
      checks += 2;
      if (n != TIMEOUT) begin
         errors++;
         $display("FAIL timeout_cycles: got %0d want %0d", n, TIMEOUT);
      end
      if (seq_fail !== 1'b1 || seq_done !== 1'b0 || init_ads_ena !== 1'b0) begin
         errors++;
         $display("FAIL timeout_state: got fail=%b done=%b ena=%b want 1 0 0",
                  seq_fail, seq_done, init_ads_ena);
      end
      start = 0;
      ads_hang = 0;
      repeat (3) @(negedge clk);
      checks++;
      if (seq_fail !== 1'b0) begin
         errors++;
         $display("FAIL timeout_release: seq_fail got %b want 0", seq_fail);
      end
   endtask

   task automatic test_reset_mid();
      bit seen;
      eye_lo = 6;
      eye_hi = 12;
      start = 1;
      seen = 0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (idelay_ld && idelay_tap == 5'd8) begin
            seen = 1;
            break;
         end
      end
      repeat (SETTLE + 2) @(negedge clk);
      checks++;
      if (!seen || idelay_tap !== 5'd8) begin
         errors++;
         $display("FAIL mid_check_reach: seen=%b tap got %0d want 8", seen, idelay_tap);
      end
      rst_n = 0;
      #1;
      check_outputs_zero("reset_mid_check");
      start = 0;
      @(negedge clk);
      rst_n = 1;
      repeat (2) @(negedge clk);
      run_eye(6, 12, '{tap: 9, done: 1, fail: 0, cal: 1, lds: 15, rises: 2});
   endtask

   task automatic test_edge_taps();
      run_eye(31, 31, '{tap: 31, done: 1, fail: 0, cal: 1, lds: 33, rises: 2});
      run_eye(0, 0, '{tap: 0, done: 1, fail: 0, cal: 1, lds: 3, rises: 2});
   endtask

   task automatic test_dac();
      int d0;
      d0 = dac_rises;
      run_eye(6, 12, '{tap: 9, done: 1, fail: 0, cal: 1, lds: 15, rises: 2});
      checks += 2;
      if (dac_rises - d0 != EXP_DAC) begin
         errors++;
         $display("FAIL dac_ena_rises: got %0d want %0d", dac_rises - d0, EXP_DAC);
      end
      if (cal_viol != 0) begin
         errors++;
         $display("FAIL cal_vs_ads_ena: %0d changes while ena high, want 0", cal_viol);
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_no_eye();
      test_timeout();
      test_reset_mid();
      test_edge_taps();
      test_dac();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
